// File: rtl/gpu_pkg.sv
// Shared framebuffer geometry and arbiter state encoding for the GPU write path.
package gpu_pkg;

  localparam int unsigned FBUF_ADDR_WIDTH = 19;
  localparam int unsigned FBUF_DATA_WIDTH = 8;
  localparam int unsigned FBUF_DEPTH      = 307200;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    return IW'(s % N);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!grant_vld && req[rot_idx(ptr, i)]) begin
        grant_vld                = 1'b1;
        grant_idx                = rot_idx(ptr, i);
        grant[rot_idx(ptr, i)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fbuf_write_arbiter.sv
// Shares the framebuffer BRAM write port between NUM_REQ sources with
// round-robin arbitration, burst locking, a burst-length cap and an owner idle timeout.
module fbuf_write_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter int unsigned AW           = FBUF_ADDR_WIDTH,
  parameter int unsigned DW           = FBUF_DATA_WIDTH,
  parameter int unsigned IW           = $clog2(NUM_REQ)
) (
  input  logic                  s_axi_ctrl_aclk,
  input  logic                  s_axi_ctrl_aresetn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic                  fbuf_en_wr,
  output logic                  fbuf_wrea,
  output logic [AW-1:0]         fbuf_addr,
  output logic [DW-1:0]         fbuf_data,
  output logic [IW-1:0]         grant_idx,
  output logic                  busy,
  output logic                  err_oob
);

  localparam int unsigned BCW = $clog2(MAX_BURST + 1);
  localparam int unsigned ICW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t     state_q, state_d;
  logic [IW-1:0]  grant_idx_q, grant_idx_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
  logic           en_q, en_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  data_q, data_d;
  logic           err_q, err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_vld;
  logic               acc;
  logic [IW-1:0]      acc_idx;
  logic [AW-1:0]      acc_addr;
  logic [DW-1:0]      acc_data;
  logic               acc_last;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
  endfunction

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Ready is gated by reset so nothing is accepted while the port is held in reset.
  always_comb begin
    req_ready = '0;
    if (s_axi_ctrl_aresetn) begin
      if (state_q == ARB_IDLE) begin
        req_ready = arb_grant;
      end else begin
        req_ready[grant_idx_q] = req_valid[grant_idx_q];
      end
    end
  end

  always_comb begin
    acc      = |req_ready;
    acc_idx  = (state_q == ARB_IDLE) ? arb_idx : grant_idx_q;
    acc_addr = req_addr[acc_idx*AW +: AW];
    acc_data = req_data[acc_idx*DW +: DW];
    acc_last = req_last[acc_idx];
  end

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    en_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    err_d       = 1'b0;

    if (acc) begin
      if (acc_addr >= AW'(FBUF_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        en_d   = 1'b1;
        addr_d = acc_addr;
        data_d = acc_data;
      end
    end

    if (state_q == ARB_IDLE) begin
      if (acc) begin
        grant_idx_d = arb_idx;
        if (!acc_last && (MAX_BURST > 1)) begin
          state_d    = ARB_LOCKED;
          beat_cnt_d = BCW'(1);
          idle_cnt_d = '0;
        end else begin
          rr_ptr_d = next_ptr(arb_idx);
        end
      end
    end else begin
      // Any release cause lands in IDLE so the next cycle arbitrates without a bubble.
      if (acc) begin
        beat_cnt_d = beat_cnt_q + BCW'(1);
        idle_cnt_d = '0;
        if (acc_last || (beat_cnt_q + BCW'(1) >= BCW'(MAX_BURST))) begin
          state_d = ARB_IDLE;
        end
      end else begin
        idle_cnt_d = idle_cnt_q + ICW'(1);
        if (idle_cnt_q + ICW'(1) >= ICW'(IDLE_TIMEOUT)) begin
          state_d = ARB_IDLE;
        end
      end
      if (state_d == ARB_IDLE) begin
        rr_ptr_d   = next_ptr(grant_idx_q);
        beat_cnt_d = '0;
        idle_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge s_axi_ctrl_aclk) begin
    if (!s_axi_ctrl_aresetn) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign fbuf_en_wr = en_q;
  assign fbuf_wrea  = en_q;
  assign fbuf_addr  = addr_q;
  assign fbuf_data  = data_q;
  assign grant_idx  = grant_idx_q;
  assign busy       = (state_q == ARB_LOCKED);
  assign err_oob    = err_q;

endmodule
